// File: rtl/psk_rx_pkg.sv
// Shared types and constants for the PSK receive chain.
package psk_rx_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic MODE_BPSK = 1'b0;
    localparam logic MODE_QPSK = 1'b1;

    localparam logic [31:0] DEF_SYNC_WORD = 32'h1ACFFC1D;

endpackage

// File: rtl/sync_correlator.sv
// Hamming-distance sync correlator: registered true/inverted match flags.
module sync_correlator
    import psk_rx_pkg::*;
#(
    parameter int unsigned          SYNC_LEN  = 32,
    parameter logic [SYNC_LEN-1:0]  SYNC_WORD = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int unsigned          MAX_ERR   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SYNC_LEN-1:0] sr,
    output logic                hit0,
    output logic                hit1
);

    localparam int unsigned CW = $clog2(SYNC_LEN + 1);

    logic [SYNC_LEN-1:0] diff_c;
    logic [CW-1:0]       dist_c;
    logic                hit0_c;
    logic                hit1_c;

    assign diff_c = sr ^ SYNC_WORD;

    always_comb begin
        dist_c = '0;
        for (int unsigned i = 0; i < SYNC_LEN; i++) begin
            dist_c = dist_c + CW'(diff_c[i]);
        end
        hit0_c = (dist_c <= CW'(MAX_ERR));
        // inverted match only when the direct match does not already win
        hit1_c = !hit0_c && ((CW'(SYNC_LEN) - dist_c) <= CW'(MAX_ERR));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit0 <= 1'b0;
            hit1 <= 1'b0;
        end else begin
            hit0 <= hit0_c;
            hit1 <= hit1_c;
        end
    end

endmodule

// File: rtl/psk_frame_sync.sv
// BPSK/QPSK hard decision, sync-word search with 180-degree ambiguity, payload byte framing.
module psk_frame_sync
    import psk_rx_pkg::*;
#(
    parameter int unsigned          WIDTH         = 16,
    parameter int unsigned          SYNC_LEN      = 32,
    parameter logic [SYNC_LEN-1:0]  SYNC_WORD     = SYNC_LEN'(DEF_SYNC_WORD),
    parameter int unsigned          MAX_ERR       = 2,
    parameter int unsigned          PAYLOAD_BYTES = 64
) (
    input  logic             clk_32M768,
    input  logic             rst_32M768,
    input  logic [WIDTH-1:0] I_1M,
    input  logic [WIDTH-1:0] Q_1M,
    input  logic             sym_clk,
    input  logic             mode,
    output logic [7:0]       byte_data,
    output logic             byte_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             locked,
    output logic             polarity,
    output logic             overrun,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned FILL_W = $clog2(SYNC_LEN + 1);
    localparam int unsigned BYTE_W = $clog2(PAYLOAD_BYTES + 1);

    state_t              state, state_nxt;
    logic                sym_q, stb_c, busy_c, take_stb_c;
    logic                mode_q, mode_c;
    logic                i_vld, i_bit, q_wait, q_vld, q_bit;
    logic                bit_vld_c, bit_c;
    logic                pb_vld, pb_bit;
    logic [SYNC_LEN-1:0] sr, sr_base_c, sr_nxt_c;
    logic [FILL_W-1:0]   fill;
    logic                fill_ok;
    logic                hit0, hit1, hit_c;
    logic [6:0]          acc;
    logic [2:0]          bit_cnt;
    logic [BYTE_W-1:0]   byte_cnt;
    logic                lock_c, take_c, pol_c, byte_done_c, last_c;

    sync_correlator #(
        .SYNC_LEN  (SYNC_LEN),
        .SYNC_WORD (SYNC_WORD),
        .MAX_ERR   (MAX_ERR)
    ) u_corr (
        .clk  (clk_32M768),
        .rst  (rst_32M768),
        .sr   (sr),
        .hit0 (hit0),
        .hit1 (hit1)
    );

    // Symbol strobe, decision pipeline and serial bit source
    assign stb_c      = sym_clk & ~sym_q;
    assign busy_c     = q_wait | q_vld;
    assign take_stb_c = stb_c & ~busy_c;
    assign mode_c     = (state == SEARCH) ? mode : mode_q;
    assign bit_vld_c  = i_vld | q_vld;
    assign bit_c      = q_vld ? q_bit : i_bit;

    // Entering SEARCH clears sr; a bit arriving in that same cycle still lands
    assign sr_base_c = last_c ? '0 : sr;
    assign sr_nxt_c  = bit_vld_c ? {sr_base_c[SYNC_LEN-2:0], bit_c} : sr_base_c;

    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) state <= SEARCH;
        else            state <= state_nxt;
    end

    // Payload consumes the bit stream one cycle late so bits racing the registered hit are kept
    always_comb begin
        state_nxt   = state;
        lock_c      = 1'b0;
        take_c      = 1'b0;
        pol_c       = polarity;
        hit_c       = fill_ok & (hit0 | hit1);
        case (state)
            SEARCH: begin
                if (hit_c) begin
                    lock_c    = 1'b1;
                    pol_c     = hit1;
                    take_c    = pb_vld;
                    state_nxt = LOCKED;
                end
            end
            LOCKED:  take_c = pb_vld;
            default: state_nxt = SEARCH;
        endcase
        byte_done_c = take_c && (bit_cnt == 3'd7);
        last_c      = byte_done_c && (byte_cnt == BYTE_W'(PAYLOAD_BYTES - 1));
        if (last_c) state_nxt = SEARCH;
    end

    always_ff @(posedge clk_32M768 or posedge rst_32M768) begin
        if (rst_32M768) begin
            sym_q       <= 1'b0;
            mode_q      <= MODE_BPSK;
            i_vld       <= 1'b0;
            i_bit       <= 1'b0;
            q_wait      <= 1'b0;
            q_vld       <= 1'b0;
            q_bit       <= 1'b0;
            pb_vld      <= 1'b0;
            pb_bit      <= 1'b0;
            sr          <= '0;
            fill        <= '0;
            fill_ok     <= 1'b0;
            acc         <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            locked      <= 1'b0;
            polarity    <= 1'b0;
            overrun     <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            sym_q  <= sym_clk;
            i_vld  <= take_stb_c;
            q_wait <= take_stb_c && (mode_c == MODE_QPSK);
            q_vld  <= q_wait;
            if (take_stb_c) begin
                i_bit <= ($signed(I_1M) >= $signed(WIDTH'(0)));
                q_bit <= ($signed(Q_1M) >= $signed(WIDTH'(0)));
                if (state == SEARCH) mode_q <= mode;
            end
            if (stb_c && busy_c) overrun <= 1'b1;

            pb_vld <= bit_vld_c;
            pb_bit <= bit_c;
            sr     <= sr_nxt_c;
            if (last_c) begin
                fill    <= bit_vld_c ? FILL_W'(1) : '0;
                fill_ok <= 1'b0;
            end else begin
                if (bit_vld_c && (fill != FILL_W'(SYNC_LEN))) fill <= fill + FILL_W'(1);
                fill_ok <= (fill == FILL_W'(SYNC_LEN));
            end

            if (lock_c) begin
                locked   <= 1'b1;
                polarity <= pol_c;
            end

            byte_valid  <= byte_done_c;
            frame_start <= byte_done_c && (byte_cnt == '0);
            frame_end   <= last_c;
            if (take_c) begin
                if (byte_done_c) begin
                    byte_data <= {acc, pb_bit ^ pol_c};
                    bit_cnt   <= '0;
                    byte_cnt  <= last_c ? '0 : byte_cnt + BYTE_W'(1);
                end else begin
                    acc     <= {acc[5:0], pb_bit ^ pol_c};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (last_c) begin
                locked    <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psk_frame_sync.sv
// Scoreboard bench for psk_frame_sync: expected payload bytes queued as symbols are driven.
module tb_psk_frame_sync;

    localparam logic [31:0] SYNC = 32'h1ACFFC1D;
    localparam logic [15:0] POS  = 16'h0BB8;
    localparam logic [15:0] NEG  = 16'hF448;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] I_1M, Q_1M;
    logic        sym_clk, mode;
    logic [7:0]  byte_data;
    logic        byte_valid, frame_start, frame_end, locked, polarity, overrun;
    logic [15:0] frame_cnt;

    typedef struct packed {
        logic [7:0] data;
        logic       fs;
        logic       fe;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   bytes_seen  = 0;

    always #5 clk = ~clk;

    psk_frame_sync dut (
        .clk_32M768  (clk),
        .rst_32M768  (rst),
        .I_1M        (I_1M),
        .Q_1M        (Q_1M),
        .sym_clk     (sym_clk),
        .mode        (mode),
        .byte_data   (byte_data),
        .byte_valid  (byte_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .polarity    (polarity),
        .overrun     (overrun),
        .frame_cnt   (frame_cnt)
    );

    function automatic logic [7:0] pay(input int k);
        if (k == 0) return 8'hA5;
        if (k == 1) return 8'h3C;
        return 8'(k * 29 + 7);
    endfunction

    // Scoreboard: every byte_valid pops and checks one expected byte
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && byte_valid === 1'b1) begin
            bytes_seen++;
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_byte got=%h fs=%b fe=%b, none expected", byte_data, frame_start, frame_end);
            end else begin
                e = sb.pop_front();
                if ({byte_data, frame_start, frame_end} !== {e.data, e.fs, e.fe}) begin
                    miscompares++;
                    $display("FAIL byte got=%h fs=%b fe=%b exp=%h fs=%b fe=%b",
                             byte_data, frame_start, frame_end, e.data, e.fs, e.fe);
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; sym_clk = 1'b0; I_1M = '0; Q_1M = '0; mode = 1'b0;
        sb.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_sym(input logic ib, input logic qb, input int per);
        I_1M    = ib ? POS : NEG;
        Q_1M    = qb ? POS : NEG;
        sym_clk = 1'b1;
        repeat (per / 2) @(negedge clk);
        sym_clk = 1'b0;
        repeat (per - per / 2) @(negedge clk);
    endtask

    task automatic send_bpsk(input logic [31:0] w, input int n, input int per);
        for (int i = n - 1; i >= 0; i--) send_sym(w[i], 1'b0, per);
    endtask

    task automatic send_qpsk(input logic [31:0] w, input int n, input int per);
        for (int i = n - 1; i >= 1; i -= 2) send_sym(w[i], w[i-1], per);
    endtask

    task automatic push_byte(input int k);
        exp_t e;
        e.data = pay(k);
        e.fs   = (k == 0);
        e.fe   = (k == 63);
        sb.push_back(e);
    endtask

    task automatic check_lock(input string name, input logic exp_pol);
        repeat (2) @(negedge clk);
        vectors++;
        if ({locked, polarity} !== {1'b1, exp_pol}) begin
            miscompares++;
            $display("FAIL %s_lock locked=%b pol=%b exp locked=1 pol=%b", name, locked, polarity, exp_pol);
        end
    endtask

    task automatic check_done(input string name, input int seen0, input logic [15:0] exp_cnt);
        repeat (20) @(negedge clk);
        vectors++;
        if (sb.size() != 0 || bytes_seen - seen0 != 64) begin
            miscompares++;
            $display("FAIL %s_bytes got=%0d pending=%0d exp=64 pending=0", name, bytes_seen - seen0, sb.size());
        end
        vectors++;
        if ({locked, frame_cnt} !== {1'b0, exp_cnt}) begin
            miscompares++;
            $display("FAIL %s_end locked=%b cnt=%0d exp locked=0 cnt=%0d", name, locked, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sym_clk = 1'b0; I_1M = POS; Q_1M = POS; mode = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({byte_data, byte_valid, frame_start, frame_end, locked, polarity, overrun, frame_cnt} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs data=%h bv=%b fs=%b fe=%b lk=%b pol=%b ovr=%b cnt=%0d exp all 0",
                     byte_data, byte_valid, frame_start, frame_end, locked, polarity, overrun, frame_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_bpsk_frame();
        int seen0;
        do_reset();
        send_bpsk(SYNC, 32, 32);
        check_lock("bpsk", 1'b0);
        seen0 = bytes_seen;
        for (int k = 0; k < 64; k++) begin
            push_byte(k);
            send_bpsk({24'h0, pay(k)}, 8, 32);
        end
        check_done("bpsk", seen0, 16'd1);
    endtask

    task automatic test_bpsk_inverted();
        int seen0;
        do_reset();
        send_bpsk(~SYNC, 32, 8);
        check_lock("inv", 1'b1);
        seen0 = bytes_seen;
        for (int k = 0; k < 64; k++) begin
            push_byte(k);
            send_bpsk({24'h0, ~pay(k)}, 8, 8);
        end
        check_done("inv", seen0, 16'd1);
        vectors++;
        if (polarity !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_pol_hold got=%b exp=1", polarity);
        end
    endtask

    task automatic test_qpsk_frame();
        int seen0;
        do_reset();
        mode = 1'b1;
        send_qpsk(SYNC, 32, 8);
        check_lock("qpsk", 1'b0);
        seen0 = bytes_seen;
        for (int k = 0; k < 64; k++) begin
            push_byte(k);
            send_qpsk({24'h0, pay(k)}, 8, 8);
        end
        check_done("qpsk", seen0, 16'd1);
    endtask

    task automatic test_overrun();
        do_reset();
        mode = 1'b1;
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_init got=%b exp=0", overrun);
        end
        I_1M = POS; Q_1M = NEG;
        sym_clk = 1'b1; @(negedge clk);
        sym_clk = 1'b0; @(negedge clk);
        sym_clk = 1'b1; @(negedge clk);
        sym_clk = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_set got=%b exp=1", overrun);
        end
        for (int k = 0; k < 6; k++) send_sym(k[0], ~k[0], 8);
        vectors++;
        if (overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL ovr_sticky got=%b exp=1", overrun);
        end
        do_reset();
        vectors++;
        if (overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL ovr_clear got=%b exp=0", overrun);
        end
    endtask

    task automatic test_sync_errors();
        int seen0;
        do_reset();
        seen0 = bytes_seen;
        send_bpsk(SYNC ^ 32'h0000_0111, 32, 8);
        repeat (10) @(negedge clk);
        vectors++;
        if (locked !== 1'b0 || bytes_seen != seen0) begin
            miscompares++;
            $display("FAIL err3_nolock locked=%b bytes=%0d exp locked=0 bytes=0", locked, bytes_seen - seen0);
        end
        do_reset();
        send_bpsk(SYNC ^ 32'h8000_0001, 32, 8);
        check_lock("err2", 1'b0);
        seen0 = bytes_seen;
        for (int k = 0; k < 64; k++) begin
            push_byte(k);
            send_bpsk({24'h0, pay(k)}, 8, 8);
        end
        check_done("err2", seen0, 16'd1);
    endtask

    task automatic test_reset_midframe();
        int seen0;
        send_bpsk(SYNC, 32, 8);
        check_lock("mid", 1'b0);
        seen0 = bytes_seen;
        for (int k = 0; k < 30; k++) begin
            push_byte(k);
            send_bpsk({24'h0, pay(k)}, 8, 8);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (bytes_seen - seen0 != 30) begin
            miscompares++;
            $display("FAIL mid_partial got=%0d exp=30", bytes_seen - seen0);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({byte_data, byte_valid, frame_start, frame_end, locked, polarity, overrun, frame_cnt} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset data=%h bv=%b fs=%b fe=%b lk=%b pol=%b ovr=%b cnt=%0d exp all 0",
                     byte_data, byte_valid, frame_start, frame_end, locked, polarity, overrun, frame_cnt);
        end
        sb.delete();
        sym_clk = 1'b0; mode = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_bpsk(SYNC, 32, 8);
        check_lock("relock", 1'b0);
        seen0 = bytes_seen;
        for (int k = 0; k < 64; k++) begin
            push_byte(k);
            send_bpsk({24'h0, pay(k)}, 8, 8);
        end
        check_done("relock", seen0, 16'd1);
    endtask

    initial begin
        test_reset();
        test_bpsk_frame();
        test_bpsk_inverted();
        test_qpsk_frame();
        test_overrun();
        test_sync_errors();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
